// File: rtl/bf_pkg.sv
// Shared definitions for the bf interpreter core: opcodes, FSM states, error codes.
package bf_pkg;

  localparam logic [3:0] OP_HALT  = 4'd0;
  localparam logic [3:0] OP_INC   = 4'd1;
  localparam logic [3:0] OP_DEC   = 4'd2;
  localparam logic [3:0] OP_LEFT  = 4'd3;
  localparam logic [3:0] OP_RIGHT = 4'd4;
  localparam logic [3:0] OP_IN    = 4'd5;
  localparam logic [3:0] OP_OUT   = 4'd6;
  localparam logic [3:0] OP_OPEN  = 4'd7;
  localparam logic [3:0] OP_CLOSE = 4'd8;
  localparam logic [3:0] OP_NOP   = 4'd9;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd1;
  localparam logic [1:0] ERR_UNMATCHED = 2'd2;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_RUN      = 3'd2,
    ST_SKIP     = 3'd3,
    ST_IN_WAIT  = 3'd4,
    ST_OUT_WAIT = 3'd5,
    ST_HALT     = 3'd6,
    ST_ERR      = 3'd7
  } state_t;

  function automatic logic state_busy(input state_t s);
    return (s == ST_CLEAR) || (s == ST_RUN) || (s == ST_SKIP) ||
           (s == ST_IN_WAIT) || (s == ST_OUT_WAIT);
  endfunction

endpackage

// File: rtl/bf_if.sv
// Host-facing bundle of the bf core: program loader, byte streams and status.
interface bf_if #(
  parameter int C = 8,
  parameter int M = 8,
  parameter int W = 8
);
  logic         prog_we;
  logic [C-1:0] prog_addr;
  logic [3:0]   prog_data;
  logic         start;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         halted;
  logic         err;
  logic [1:0]   err_code;
  logic [C-1:0] pc;
  logic [M-1:0] ptr;

  modport master (
    output prog_we, prog_addr, prog_data, start, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, busy, halted, err, err_code, pc, ptr
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, busy, halted, err, err_code, pc, ptr
  );
endinterface

// File: rtl/bf_stack.sv
// Bracket return-address LIFO; the top counter is one bit wider than the
// address so full/empty fall straight out of it.
module bf_stack #(
  parameter int S = 5,
  parameter int C = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [C-1:0] i_data,
  output logic [C-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  logic [C-1:0] r_mem [2**S];
  logic [S:0]   r_top;
  logic [S:0]   w_top_m1;

  assign w_top_m1 = r_top - (S+1)'(1);
  assign o_full   = r_top[S];
  assign o_empty  = (r_top == '0);
  assign o_data   = r_mem[w_top_m1[S-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_top <= '0;
    end else if (i_clr) begin
      r_top <= '0;
    end else if (i_push && !o_full) begin
      r_top <= r_top + (S+1)'(1);
    end else if (i_pop && !o_empty) begin
      r_top <= w_top_m1;
    end else begin
      r_top <= r_top;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !o_full) begin
      r_mem[r_top[S-1:0]] <= i_data;
    end
  end

endmodule

// File: rtl/bf_core.sv
// Brainfuck-class interpreter: program RAM, cell RAM, bracket LIFO and a
// one-opcode-per-cycle FSM with valid/ready byte streams for ',' and '.'.
module bf_core
  import bf_pkg::*;
#(
  parameter int C = 8,
  parameter int M = 8,
  parameter int S = 5,
  parameter int W = 8
) (
  input logic clk,
  input logic rst,
  bf_if.slave bus
);

  localparam logic [C-1:0] PC_LAST  = {C{1'b1}};
  localparam logic [M-1:0] CLR_LAST = {M{1'b1}};

  logic [3:0]   r_prog  [2**C];
  logic [W-1:0] r_cells [2**M];

  state_t       r_state, w_state_nxt;
  logic [C-1:0] r_pc, w_pc_nxt, r_depth, w_depth_nxt;
  logic [M-1:0] r_ptr, w_ptr_nxt, r_clr, w_clr_nxt;
  logic [1:0]   r_err_code, w_err_code_nxt;
  logic [W-1:0] r_out_data, w_out_data_nxt;
  logic         r_out_valid, w_out_valid_nxt;
  logic         r_in_ready, r_busy, r_halted, r_err;

  logic [3:0]   w_op;
  logic [W-1:0] w_cell;
  logic         w_cell_we;
  logic [M-1:0] w_cell_addr;
  logic [W-1:0] w_cell_wdata;
  logic         w_adv, w_push, w_pop, w_stk_clr, w_full, w_empty, w_pc_last;
  logic [C-1:0] w_stk_data;

  assign w_op      = r_prog[r_pc];
  assign w_cell    = r_cells[r_ptr];
  assign w_pc_last = (r_pc == PC_LAST);

  bf_stack #(.S(S), .C(C)) u_stack (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_stk_clr),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (r_pc),
    .o_data  (w_stk_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (bus.prog_we && (r_state == ST_IDLE)) begin
      r_prog[bus.prog_addr] <= bus.prog_data;
    end
    if (w_cell_we) begin
      r_cells[w_cell_addr] <= w_cell_wdata;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_ptr_nxt       = r_ptr;
    w_depth_nxt     = r_depth;
    w_clr_nxt       = r_clr;
    w_err_code_nxt  = r_err_code;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
    w_cell_we       = 1'b0;
    w_cell_addr     = r_ptr;
    w_cell_wdata    = w_cell;
    w_push          = 1'b0;
    w_pop           = 1'b0;
    w_stk_clr       = 1'b0;
    w_adv           = 1'b0;

    case (r_state)
      ST_IDLE, ST_HALT, ST_ERR: begin
        if (bus.start) begin
          w_state_nxt = ST_CLEAR;
          w_clr_nxt   = '0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_CLEAR: begin
        w_cell_we    = 1'b1;
        w_cell_addr  = r_clr;
        w_cell_wdata = '0;
        w_clr_nxt    = r_clr + M'(1);
        if (r_clr == CLR_LAST) begin
          w_state_nxt    = ST_RUN;
          w_pc_nxt       = '0;
          w_ptr_nxt      = '0;
          w_depth_nxt    = '0;
          w_err_code_nxt = ERR_NONE;
          w_stk_clr      = 1'b1;
        end else begin
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_RUN: begin
        case (w_op)
          OP_HALT:  w_state_nxt = ST_HALT;
          OP_INC: begin
            w_cell_we    = 1'b1;
            w_cell_wdata = w_cell + W'(1);
            w_adv        = 1'b1;
          end
          OP_DEC: begin
            w_cell_we    = 1'b1;
            w_cell_wdata = w_cell - W'(1);
            w_adv        = 1'b1;
          end
          OP_LEFT: begin
            w_ptr_nxt = r_ptr - M'(1);
            w_adv     = 1'b1;
          end
          OP_RIGHT: begin
            w_ptr_nxt = r_ptr + M'(1);
            w_adv     = 1'b1;
          end
          OP_IN:    w_state_nxt = ST_IN_WAIT;
          OP_OUT: begin
            w_out_data_nxt  = w_cell;
            w_out_valid_nxt = 1'b1;
            w_state_nxt     = ST_OUT_WAIT;
          end
          OP_OPEN: begin
            // A zero-cell '[' on the last address has nowhere left to find its ']'.
            if (w_cell != '0) begin
              if (w_full) begin
                w_state_nxt    = ST_ERR;
                w_err_code_nxt = ERR_OVERFLOW;
              end else begin
                w_push = 1'b1;
                w_adv  = 1'b1;
              end
            end else if (w_pc_last) begin
              w_state_nxt    = ST_ERR;
              w_err_code_nxt = ERR_UNMATCHED;
            end else begin
              w_depth_nxt = C'(1);
              w_pc_nxt    = r_pc + C'(1);
              w_state_nxt = ST_SKIP;
            end
          end
          OP_CLOSE: begin
            if (w_empty) begin
              w_state_nxt    = ST_ERR;
              w_err_code_nxt = ERR_UNDERFLOW;
            end else begin
              w_pop    = 1'b1;
              w_pc_nxt = w_stk_data;
            end
          end
          default:  w_adv = 1'b1;
        endcase
      end
      ST_SKIP: begin
        if ((w_op == OP_CLOSE) && (r_depth == C'(1))) begin
          w_depth_nxt = '0;
          w_adv       = 1'b1;
        end else begin
          if (w_op == OP_OPEN) begin
            w_depth_nxt = r_depth + C'(1);
          end else if (w_op == OP_CLOSE) begin
            w_depth_nxt = r_depth - C'(1);
          end else begin
            w_depth_nxt = r_depth;
          end
          if (w_pc_last) begin
            w_state_nxt    = ST_ERR;
            w_err_code_nxt = ERR_UNMATCHED;
          end else begin
            w_pc_nxt = r_pc + C'(1);
          end
        end
      end
      ST_IN_WAIT: begin
        if (bus.in_valid) begin
          w_cell_we    = 1'b1;
          w_cell_wdata = bus.in_data;
          w_adv        = 1'b1;
        end else begin
          w_state_nxt = ST_IN_WAIT;
        end
      end
      ST_OUT_WAIT: begin
        if (bus.out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_adv           = 1'b1;
        end else begin
          w_state_nxt = ST_OUT_WAIT;
        end
      end
      default:  w_state_nxt = ST_IDLE;
    endcase

    // Falling off the end of program memory halts with pc wrapped to 0.
    if (w_adv) begin
      w_pc_nxt    = r_pc + C'(1);
      w_state_nxt = w_pc_last ? ST_HALT : ST_RUN;
    end else begin
      w_pc_nxt = w_pc_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pc        <= '0;
      r_ptr       <= '0;
      r_depth     <= '0;
      r_clr       <= '0;
      r_err_code  <= ERR_NONE;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_halted    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_ptr       <= w_ptr_nxt;
      r_depth     <= w_depth_nxt;
      r_clr       <= w_clr_nxt;
      r_err_code  <= w_err_code_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_in_ready  <= (w_state_nxt == ST_IN_WAIT);
      r_busy      <= state_busy(w_state_nxt);
      r_halted    <= (w_state_nxt == ST_HALT);
      r_err       <= (w_state_nxt == ST_ERR);
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.halted    = r_halted;
  assign bus.err       = r_err;
  assign bus.err_code  = r_err_code;
  assign bus.pc        = r_pc;
  assign bus.ptr       = r_ptr;

endmodule

// File: tb/tb_bf_core.sv
// Directed and randomized bench for bf_core; random programs are checked
// against a plain interpreter that matches brackets by forward scanning.
module tb_bf_core;
  import bf_pkg::*;

  localparam int C = 5;
  localparam int M = 4;
  localparam int S = 2;
  localparam int W = 8;
  localparam int NPROG = 2**C;
  localparam int NCELL = 2**M;
  localparam int NSTK  = 2**S;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bf_if #(.C(C), .M(M), .W(W)) bus ();
  bf_core #(.C(C), .M(M), .S(S), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [3:0] prog [NPROG];
  logic [7:0] in_q [$];
  logic [7:0] got [$];
  int first_out;
  int open_cnt;

  logic [7:0] m_in [$];
  logic [7:0] m_out [$];
  int m_halt, m_err, m_code, m_pc, m_ptr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.prog_we = 1'b0; bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill(input logic [3:0] v);
    for (int i = 0; i < NPROG; i++) prog[i] = v;
  endtask

  task automatic load();
    for (int i = 0; i < NPROG; i++) begin
      @(negedge clk);
      bus.prog_we = 1'b1; bus.prog_addr = C'(i); bus.prog_data = prog[i];
    end
    @(negedge clk);
    bus.prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Serves the streams until halted/err; mode 1 throttles both handshakes randomly.
  task automatic run_loop(input string tag, input int mode, input int budget);
    int cyc = 0;
    bit done = 1'b0;
    got.delete(); first_out = -1; open_cnt = 0;
    while (!done && cyc < budget) begin
      if (bus.halted || bus.err) begin
        done = 1'b1;
      end else begin
        if (bus.busy && bus.pc == C'(1)) open_cnt++;
        if (bus.out_valid && first_out < 0) first_out = cyc;
        bus.in_valid  = (in_q.size() > 0) && (mode == 0 || $urandom_range(3) != 0);
        bus.in_data   = (in_q.size() > 0) ? in_q[0] : 8'd0;
        bus.out_ready = (mode == 0) || ($urandom_range(3) != 0);
        if (bus.in_valid && bus.in_ready) void'(in_q.pop_front());
        if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
        @(negedge clk);
        cyc++;
      end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  // Reference interpreter; returns 0 if the program needs too many steps or inputs.
  function automatic bit model_run();
    logic [7:0] cells [NCELL];
    int stk [$];
    int pc = 0, ptr = 0, k = 0;
    bit adv;
    for (int i = 0; i < NCELL; i++) cells[i] = 8'd0;
    m_out.delete();
    m_halt = 0; m_err = 0; m_code = 0;
    for (int step = 0; step < 1500; step++) begin
      adv = 1'b0;
      case (prog[pc])
        OP_HALT: begin m_halt = 1; m_pc = pc; m_ptr = ptr; return 1'b1; end
        OP_INC:   begin cells[ptr] = cells[ptr] + 8'd1; adv = 1'b1; end
        OP_DEC:   begin cells[ptr] = cells[ptr] - 8'd1; adv = 1'b1; end
        OP_LEFT:  begin ptr = (ptr + NCELL - 1) % NCELL; adv = 1'b1; end
        OP_RIGHT: begin ptr = (ptr + 1) % NCELL; adv = 1'b1; end
        OP_IN: begin
          if (k >= m_in.size()) return 1'b0;
          cells[ptr] = m_in[k]; k++; adv = 1'b1;
        end
        OP_OUT:   begin m_out.push_back(cells[ptr]); adv = 1'b1; end
        OP_OPEN: begin
          if (cells[ptr] != 8'd0) begin
            if (stk.size() == NSTK) begin
              m_err = 1; m_code = 1; m_pc = pc; m_ptr = ptr; return 1'b1;
            end
            stk.push_back(pc); adv = 1'b1;
          end else begin
            int d = 1;
            int q = pc + 1;
            while (1) begin
              if (q >= NPROG) begin
                m_err = 1; m_code = 2; m_pc = NPROG - 1; m_ptr = ptr; return 1'b1;
              end
              if (prog[q] == OP_OPEN) d++;
              if (prog[q] == OP_CLOSE) d--;
              if (d == 0) break;
              q++;
            end
            pc = q; adv = 1'b1;
          end
        end
        OP_CLOSE: begin
          if (stk.size() == 0) begin
            m_err = 1; m_code = 3; m_pc = pc; m_ptr = ptr; return 1'b1;
          end
          pc = stk.pop_back();
        end
        default: adv = 1'b1;
      endcase
      if (adv) begin
        if (pc == NPROG - 1) begin
          m_halt = 1; m_pc = 0; m_ptr = ptr; return 1'b1;
        end
        pc++;
      end
    end
    return 1'b0;
  endfunction

  initial begin
    bit stable;
    logic [7:0] d0;
    logic [C-1:0] pc0;
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = 4'd0; bus.start = 1'b0;
    bus.in_data = 8'd0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    do_reset();

    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_code", 32'(bus.err_code), 32'd0);
    check("rst_pc", 32'(bus.pc), 32'd0);
    check("rst_ptr", 32'(bus.ptr), 32'd0);
    check("rst_outv", 32'(bus.out_valid), 32'd0);
    check("rst_inr", 32'(bus.in_ready), 32'd0);

    // + + + . HALT
    fill(OP_HALT);
    prog[0] = OP_INC; prog[1] = OP_INC; prog[2] = OP_INC; prog[3] = OP_OUT;
    load(); pulse_start(); run_loop("t1", 0, 200);
    check("t1_nout", got.size(), 1);
    if (got.size() > 0) check("t1_out", 32'(got[0]), 32'd3);
    check("t1_lat", first_out, NCELL + 4);
    check("t1_halt", 32'(bus.halted), 32'd1);
    check("t1_pc", 32'(bus.pc), 32'd3 + 32'd1);

    // , [ - > + < ] > . HALT with input 5
    do_reset(); fill(OP_HALT);
    prog[0] = OP_IN; prog[1] = OP_OPEN; prog[2] = OP_DEC; prog[3] = OP_RIGHT;
    prog[4] = OP_INC; prog[5] = OP_LEFT; prog[6] = OP_CLOSE; prog[7] = OP_RIGHT; prog[8] = OP_OUT;
    load(); in_q = '{8'd5}; pulse_start(); run_loop("t2", 0, 300);
    check("t2_nout", got.size(), 1);
    if (got.size() > 0) check("t2_out", 32'(got[0]), 32'd5);
    check("t2_open_execs", open_cnt, 6);
    check("t2_pc", 32'(bus.pc), 32'd9);
    check("t2_ptr", 32'(bus.ptr), 32'd1);

    // [ [ + ] ] . HALT on a zero cell
    do_reset(); fill(OP_HALT);
    prog[0] = OP_OPEN; prog[1] = OP_OPEN; prog[2] = OP_INC; prog[3] = OP_CLOSE;
    prog[4] = OP_CLOSE; prog[5] = OP_OUT;
    load(); pulse_start(); run_loop("t3", 0, 200);
    check("t3_nout", got.size(), 1);
    if (got.size() > 0) check("t3_out", 32'(got[0]), 32'd0);
    check("t3_pc", 32'(bus.pc), 32'd6);
    check("t3_halt", 32'(bus.halted), 32'd1);

    // Stall the '.' for 20 cycles; a program write during the stall is dropped.
    do_reset(); fill(OP_HALT);
    prog[0] = OP_INC; prog[1] = OP_INC; prog[2] = OP_INC; prog[3] = OP_OUT;
    load(); pulse_start();
    for (int i = 0; i < 100 && !bus.out_valid; i++) @(negedge clk);
    check("t4_valid", 32'(bus.out_valid), 32'd1);
    d0 = bus.out_data; pc0 = bus.pc; stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.prog_we = (i == 5); bus.prog_addr = C'(4); bus.prog_data = OP_INC;
      @(negedge clk);
      if (!bus.out_valid || bus.out_data !== d0 || bus.pc !== pc0) stable = 1'b0;
    end
    bus.prog_we = 1'b0;
    check("t4_stable", 32'(stable), 32'd1);
    check("t4_data", 32'(d0), 32'd3);
    check("t4_pc", 32'(pc0), 32'd3);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("t4_drop", 32'(bus.out_valid), 32'd0);
    @(negedge clk); @(negedge clk);
    check("t4_halt", 32'(bus.halted), 32'd1);
    check("t4_hpc", 32'(bus.pc), 32'd4);
    pulse_start(); run_loop("t4r", 0, 200);
    check("t4r_nout", got.size(), 1);
    if (got.size() > 0) check("t4r_out", 32'(got[0]), 32'd3);
    check("t4r_pc", 32'(bus.pc), 32'd4);

    // start together with a program write: the write lands before execution.
    do_reset(); fill(OP_HALT);
    prog[0] = OP_INC; prog[1] = OP_OUT;
    load();
    @(negedge clk);
    bus.start = 1'b1; bus.prog_we = 1'b1; bus.prog_addr = C'(0); bus.prog_data = OP_DEC;
    @(negedge clk);
    bus.start = 1'b0; bus.prog_we = 1'b0;
    run_loop("tsw", 0, 200);
    check("tsw_nout", got.size(), 1);
    if (got.size() > 0) check("tsw_out", 32'(got[0]), 32'd255);

    // Five nested '[' on a nonzero cell overflow a four-entry stack.
    do_reset(); fill(OP_HALT);
    prog[0] = OP_INC;
    for (int i = 1; i <= 5; i++) prog[i] = OP_OPEN;
    load(); pulse_start(); run_loop("t5", 0, 200);
    check("t5_err", 32'(bus.err), 32'd1);
    check("t5_code", 32'(bus.err_code), 32'd1);
    check("t5_pc", 32'(bus.pc), 32'd5);
    check("t5_busy", 32'(bus.busy), 32'd0);

    do_reset(); fill(OP_HALT);
    prog[0] = OP_CLOSE;
    load(); pulse_start(); run_loop("t5b", 0, 200);
    check("t5b_code", 32'(bus.err_code), 32'd3);
    check("t5b_pc", 32'(bus.pc), 32'd0);

    // Unclosed '[' on a zero cell scans off the end of program memory.
    do_reset(); fill(OP_NOP);
    prog[0] = OP_OPEN;
    load(); pulse_start(); run_loop("tum", 0, 200);
    check("tum_code", 32'(bus.err_code), 32'd2);
    check("tum_pc", 32'(bus.pc), 32'(NPROG - 1));

    // No HALT opcode: execution wraps off the last address into HALT at pc 0.
    do_reset(); fill(OP_NOP);
    prog[0] = OP_INC; prog[NPROG - 2] = OP_OUT;
    load(); pulse_start(); run_loop("twr", 0, 200);
    check("twr_nout", got.size(), 1);
    if (got.size() > 0) check("twr_out", 32'(got[0]), 32'd1);
    check("twr_halt", 32'(bus.halted), 32'd1);
    check("twr_pc", 32'(bus.pc), 32'd0);

    // Reset while waiting on ',' returns to IDLE; a rerun keeps the program.
    do_reset(); fill(OP_HALT);
    prog[0] = OP_IN; prog[1] = OP_OUT;
    load(); pulse_start();
    for (int i = 0; i < 100 && !bus.in_ready; i++) @(negedge clk);
    check("t6_inr", 32'(bus.in_ready), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_inr_rst", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("t6_busy", 32'(bus.busy), 32'd0);
    check("t6_halt", 32'(bus.halted), 32'd0);
    in_q = '{8'd42}; pulse_start(); run_loop("t6r", 0, 200);
    check("t6r_nout", got.size(), 1);
    if (got.size() > 0) check("t6r_out", 32'(got[0]), 32'd42);
    check("t6r_halt", 32'(bus.halted), 32'd1);

    // Random programs with throttled streams against the reference interpreter.
    for (int n = 0; n < 10; n++) begin
      bit ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin
        for (int i = 0; i < NPROG; i++) begin
          int r = int'($urandom_range(99));
          if (r < 3)       prog[i] = OP_HALT;
          else if (r < 20) prog[i] = OP_INC;
          else if (r < 30) prog[i] = OP_DEC;
          else if (r < 40) prog[i] = OP_LEFT;
          else if (r < 50) prog[i] = OP_RIGHT;
          else if (r < 57) prog[i] = OP_IN;
          else if (r < 67) prog[i] = OP_OUT;
          else if (r < 75) prog[i] = OP_OPEN;
          else if (r < 83) prog[i] = OP_CLOSE;
          else             prog[i] = 4'(9 + $urandom_range(6));
        end
        m_in.delete();
        for (int i = 0; i < 64; i++) m_in.push_back(8'($urandom_range(255)));
        ok = model_run();
      end
      if (ok) begin
        do_reset(); load();
        in_q = m_in;
        pulse_start(); run_loop("rnd", 1, 6000);
        check("rnd_nout", got.size(), m_out.size());
        for (int i = 0; i < got.size() && i < m_out.size(); i++)
          check("rnd_out", 32'(got[i]), 32'(m_out[i]));
        check("rnd_halt", 32'(bus.halted), 32'(m_halt));
        check("rnd_err", 32'(bus.err), 32'(m_err));
        check("rnd_code", 32'(bus.err_code), 32'(m_code));
        check("rnd_pc", 32'(bus.pc), 32'(m_pc));
        check("rnd_ptr", 32'(bus.ptr), 32'(m_ptr));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
